// File: rtl/sudoku_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_pkg
// Shared widths, FSM state encoding and requester ids for the board-RAM
// arbiter and its write-protect merge block.
// Row layout: [15:0] four 4-bit cells (cell i = [4i+3:4i]),
//             [19:16] protect mask (bit 16+i protects cell i).
// Optional feature macro used by the consumers: SUDOKU_RAM_WP_EN.
// -----------------------------------------------------------------------------
package sudoku_pkg;

   localparam int ROW_W     = 20;
   localparam int CELL_W    = 4;
   localparam int ADDR_W    = 2;
   localparam int NUM_CELLS = 4;
   localparam int MASK_LSB  = NUM_CELLS * CELL_W;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      CAPTURE = 3'd2,
      WRITE   = 3'd3,
      ACK     = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      LD  = 2'd0,
      CTL = 2'd1,
      CHK = 2'd2
   } reqId_e;

endpackage

// File: rtl/sudoku_wp_merge.sv
// -----------------------------------------------------------------------------
// sudoku_wp_merge
// Combinational write-protect merge for controller writes. Only instantiated
// when SUDOKU_RAM_WP_EN is defined.
// Ports:
//   storedRow  in  ROW_W  row currently held in RAM (mask + cells)
//   newRow     in  ROW_W  row the controller wants to write
//   mergedRow  out ROW_W  stored mask, stored protected cells, new unprotected cells
//   violation  out 1      a protected cell in newRow differs from the stored cell
// -----------------------------------------------------------------------------
module sudoku_wp_merge
   import sudoku_pkg::*;
(
   input  logic [ROW_W-1:0] storedRow,
   input  logic [ROW_W-1:0] newRow,
   output logic [ROW_W-1:0] mergedRow,
   output logic             violation
);

   always_comb begin
      // Start from the stored row so the mask bits are always preserved.
      mergedRow = storedRow;
      violation = 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (storedRow[MASK_LSB+i]) begin
            if (newRow[i*CELL_W +: CELL_W] != storedRow[i*CELL_W +: CELL_W]) begin
               violation = 1'b1;
            end
         end else begin
            mergedRow[i*CELL_W +: CELL_W] = newRow[i*CELL_W +: CELL_W];
         end
      end
   end

endmodule

// File: rtl/sudoku_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sudoku_ram_arbiter
// Shares the single board-RAM port between the puzzle loader (write-only),
// the interface controller (read/write) and the game checker (read-only).
// Every access runs IDLE -> ISSUE -> CAPTURE -> [WRITE] -> ACK.
// Optional macro SUDOKU_RAM_WP_EN: controller writes become read-modify-write
// that keeps protected cells and flags attempts to change them.
//
// Handshake: a requester raises req with addr/wdata/we stable and holds them
// until it sees its one-cycle ack; it drops req in the cycle after ack so the
// following IDLE never resamples a finished request.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   ld_req/addr/wdata/ack    loader write port
//   ctl_req/we/addr/wdata    controller request; ctl_ack, ctl_rdata, ctl_wp_err
//   chk_req/addr             checker read request; chk_ack, chk_rdata
//   ram_addr/data/wren, ram_q  RAM port (ram_q valid the cycle after ram_addr)
//   busy                     high whenever the FSM is not IDLE
//   dbgState                 current FSM state for observation
// -----------------------------------------------------------------------------
module sudoku_ram_arbiter
   import sudoku_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [ROW_W-1:0]  ld_wdata,
   output logic              ld_ack,
   input  logic              ctl_req,
   input  logic              ctl_we,
   input  logic [ADDR_W-1:0] ctl_addr,
   input  logic [ROW_W-1:0]  ctl_wdata,
   output logic              ctl_ack,
   output logic [ROW_W-1:0]  ctl_rdata,
   output logic              ctl_wp_err,
   input  logic              chk_req,
   input  logic [ADDR_W-1:0] chk_addr,
   output logic              chk_ack,
   output logic [ROW_W-1:0]  chk_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [ROW_W-1:0]  ram_data,
   output logic              ram_wren,
   input  logic [ROW_W-1:0]  ram_q,
   output logic              busy,
   output state_e            dbgState
);

   state_e            state, nextState;
   reqId_e            winId, grantId;
   logic [ADDR_W-1:0] curAddr;
   logic [ROW_W-1:0]  curWdata;
   logic              curWe;
   logic              favourChk;   // 0 = controller wins a CTL/CHK tie
   logic              anyReq;
   logic              wpWrite;     // current transaction is a protected controller write

`ifdef SUDOKU_RAM_WP_EN
   logic [ROW_W-1:0] writeBuf;
   logic [ROW_W-1:0] mergedRow;
   logic             violation;
   logic             wpErr;

   sudoku_wp_merge uMerge (
      .storedRow (ram_q),
      .newRow    (curWdata),
      .mergedRow (mergedRow),
      .violation (violation)
   );

   assign wpWrite    = (winId == CTL) && curWe;
   assign ctl_wp_err = wpErr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         writeBuf <= '0;
         wpErr    <= 1'b0;
      end else if (state == CAPTURE && wpWrite) begin
         writeBuf <= mergedRow;
         wpErr    <= violation;
      end
   end
`else
   assign wpWrite    = 1'b0;
   assign ctl_wp_err = 1'b0;
`endif

   // Loader first; controller/checker tie broken by the last-winner pointer.
   always_comb begin
      anyReq  = ld_req | ctl_req | chk_req;
      grantId = LD;
      if (ld_req) begin
         grantId = LD;
      end else if (ctl_req && chk_req) begin
         grantId = favourChk ? CHK : CTL;
      end else if (ctl_req) begin
         grantId = CTL;
      end else if (chk_req) begin
         grantId = CHK;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         winId     <= LD;
         curAddr   <= '0;
         curWdata  <= '0;
         curWe     <= 1'b0;
         favourChk <= 1'b0;
         ctl_rdata <= '0;
         chk_rdata <= '0;
      end else begin
         state <= nextState;
         if (state == IDLE && anyReq) begin
            winId <= grantId;
            case (grantId)
               LD: begin
                  curAddr  <= ld_addr;
                  curWdata <= ld_wdata;
                  curWe    <= 1'b1;
               end
               CTL: begin
                  curAddr   <= ctl_addr;
                  curWdata  <= ctl_wdata;
                  curWe     <= ctl_we;
                  favourChk <= 1'b1;
               end
               default: begin
                  curAddr   <= chk_addr;
                  curWdata  <= '0;
                  curWe     <= 1'b0;
                  favourChk <= 1'b0;
               end
            endcase
         end
         if (state == CAPTURE && !curWe) begin
            if (winId == CTL) ctl_rdata <= ram_q;
            if (winId == CHK) chk_rdata <= ram_q;
         end
      end
   end

   always_comb begin
      nextState = state;
      ram_addr  = '0;
      ram_data  = '0;
      ram_wren  = 1'b0;
      case (state)
         IDLE: begin
            if (anyReq) nextState = ISSUE;
         end
         ISSUE: begin
            // A protected write uses this slot as the read half of its RMW.
            ram_addr  = curAddr;
            ram_data  = curWdata;
            ram_wren  = curWe && !wpWrite;
            nextState = CAPTURE;
         end
         CAPTURE: begin
            nextState = wpWrite ? WRITE : ACK;
         end
`ifdef SUDOKU_RAM_WP_EN
         WRITE: begin
            ram_addr  = curAddr;
            ram_data  = writeBuf;
            ram_wren  = 1'b1;
            nextState = ACK;
         end
`endif
         ACK: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
      // A reset seen before the write edge drops the pending write.
      if (RST) ram_wren = 1'b0;
   end

   assign ld_ack   = !RST && (state == ACK) && (winId == LD);
   assign ctl_ack  = !RST && (state == ACK) && (winId == CTL);
   assign chk_ack  = !RST && (state == ACK) && (winId == CHK);
   assign busy     = (state != IDLE);
   assign dbgState = state;

endmodule

// File: tb/tb_sudoku_ram_arbiter.sv
module tb_sudoku_ram_arbiter;
  import sudoku_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic              ld_req = 0, ctl_req = 0, ctl_we = 0, chk_req = 0;
  logic [ADDR_W-1:0] ld_addr = 0, ctl_addr = 0, chk_addr = 0;
  logic [ROW_W-1:0]  ld_wdata = 0, ctl_wdata = 0;
  logic              ld_ack, ctl_ack, chk_ack, ctl_wp_err, ram_wren, busy;
  logic [ROW_W-1:0]  ctl_rdata, chk_rdata, ram_data;
  logic [ROW_W-1:0]  ram_q = 0;
  logic [ADDR_W-1:0] ram_addr;
  state_e            dbgState;

  sudoku_ram_arbiter dut (
    .CLK(CLK), .RST(RST),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .ctl_req(ctl_req), .ctl_we(ctl_we), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
    .ctl_ack(ctl_ack), .ctl_rdata(ctl_rdata), .ctl_wp_err(ctl_wp_err),
    .chk_req(chk_req), .chk_addr(chk_addr), .chk_ack(chk_ack), .chk_rdata(chk_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy), .dbgState(dbgState)
  );

  // 4 x 20 board RAM, registered read
  logic [ROW_W-1:0] mem [4];
  initial for (int i = 0; i < 4; i++) mem[i] = '0;
  always @(posedge CLK) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  // ---------------- scoreboard ----------------
  // entry = {id[1:0], isRead, data[19:0], wpErr, latency[7:0]}
  localparam int W = 32;
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int ld_req_cyc = 0, ctl_req_cyc = 0, chk_req_cyc = 0;

`ifdef SUDOKU_RAM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] id, input logic is_rd,
                                      input logic [19:0] d, input logic wpe,
                                      input logic [7:0] lat);
    return {id, is_rd, d, wpe, lat};
  endfunction

  // monitor
  logic [W-1:0] m_e;
  logic [2:0]   m_exp_ack;
  int           m_req_cyc;
  always @(negedge CLK) begin
    if (!RST && (ld_ack || ctl_ack || chk_ack)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {29'd0, ld_ack, ctl_ack, chk_ack}, 32'd0);
      end else begin
        m_e = exp_q.pop_front();
        m_exp_ack = (m_e[31:30] == 2'd0) ? 3'b100 : (m_e[31:30] == 2'd1) ? 3'b010 : 3'b001;
        m_req_cyc = (m_e[31:30] == 2'd0) ? ld_req_cyc : (m_e[31:30] == 2'd1) ? ctl_req_cyc : chk_req_cyc;
        check("ack_owner", {29'd0, ld_ack, ctl_ack, chk_ack}, {29'd0, m_exp_ack});
        check("ack_latency", cyc - m_req_cyc, {24'd0, m_e[7:0]});
        if (m_e[29]) begin
          if (m_e[31:30] == 2'd1) check("ctl_rdata", {12'd0, ctl_rdata}, {12'd0, m_e[28:9]});
          else                    check("chk_rdata", {12'd0, chk_rdata}, {12'd0, m_e[28:9]});
        end else if (m_e[31:30] == 2'd1) begin
          check("ctl_wp_err", {31'd0, ctl_wp_err}, {31'd0, m_e[8]});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic ld_write(input logic [1:0] a, input logic [19:0] d);
    int n;
    @(negedge CLK);
    ld_addr = a; ld_wdata = d; ld_req = 1'b1; ld_req_cyc = cyc;
    n = 0;
    do begin @(negedge CLK); n++; end while (!ld_ack && n < 40);
    if (!ld_ack) check("ld_ack_timeout", {31'd0, ld_ack}, 32'd1);
    @(posedge CLK); #1 ld_req = 1'b0;
  endtask

  task automatic ctl_access(input logic we, input logic [1:0] a, input logic [19:0] d);
    int n;
    @(negedge CLK);
    ctl_we = we; ctl_addr = a; ctl_wdata = d; ctl_req = 1'b1; ctl_req_cyc = cyc;
    n = 0;
    do begin @(negedge CLK); n++; end while (!ctl_ack && n < 40);
    if (!ctl_ack) check("ctl_ack_timeout", {31'd0, ctl_ack}, 32'd1);
    @(posedge CLK); #1 ctl_req = 1'b0;
  endtask

  task automatic chk_read(input logic [1:0] a);
    int n;
    @(negedge CLK);
    chk_addr = a; chk_req = 1'b1; chk_req_cyc = cyc;
    n = 0;
    do begin @(negedge CLK); n++; end while (!chk_ack && n < 40);
    if (!chk_ack) check("chk_ack_timeout", {31'd0, chk_ack}, 32'd1);
    @(posedge CLK); #1 chk_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge CLK);
    check("rst_acks", {29'd0, ld_ack, ctl_ack, chk_ack}, 32'd0);
    check("rst_ram_wren", {31'd0, ram_wren}, 32'd0);
    check("rst_ram_addr", {30'd0, ram_addr}, 32'd0);
    check("rst_ram_data", {12'd0, ram_data}, 32'd0);
    check("rst_ctl_rdata", {12'd0, ctl_rdata}, 32'd0);
    check("rst_chk_rdata", {12'd0, chk_rdata}, 32'd0);
    check("rst_wp_err", {31'd0, ctl_wp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {29'd0, dbgState}, {29'd0, IDLE});
    RST = 1'b0;

    // loader write then controller read-back
    exp_q.push_back(mk(2'd0, 1'b0, 20'h0, 1'b0, 8'd3));
    ld_write(2'd2, 20'hF1234);
    exp_q.push_back(mk(2'd1, 1'b1, 20'hF1234, 1'b0, 8'd3));
    ctl_access(1'b0, 2'd2, 20'h0);
    exp_q.push_back(mk(2'd0, 1'b0, 20'h0, 1'b0, 8'd3));
    ld_write(2'd3, 20'h12345);

    // all three from reset: LD, CTL, CHK
    pulse_reset();
    exp_q.push_back(mk(2'd0, 1'b0, 20'h0, 1'b0, 8'd3));
    exp_q.push_back(mk(2'd1, 1'b1, 20'hF1234, 1'b0, 8'd7));
    exp_q.push_back(mk(2'd2, 1'b1, 20'h00777, 1'b0, 8'd11));
    fork
      ld_write(2'd1, 20'h00777);
      ctl_access(1'b0, 2'd2, 20'h0);
      chk_read(2'd1);
    join
    // second CTL+CHK pair: CTL then CHK
    exp_q.push_back(mk(2'd1, 1'b1, 20'h00777, 1'b0, 8'd3));
    exp_q.push_back(mk(2'd2, 1'b1, 20'h12345, 1'b0, 8'd7));
    fork
      ctl_access(1'b0, 2'd1, 20'h0);
      chk_read(2'd3);
    join

    // write-protect cases (expectations depend on build)
    exp_q.push_back(mk(2'd0, 1'b0, 20'h0, 1'b0, 8'd3));
    ld_write(2'd0, 20'h1000A);
    exp_q.push_back(mk(2'd1, 1'b0, 20'h0, WP, WP ? 8'd4 : 8'd3));
    ctl_access(1'b1, 2'd0, 20'h0BCD5);
    exp_q.push_back(mk(2'd1, 1'b1, WP ? 20'h1BCDA : 20'h0BCD5, 1'b0, 8'd3));
    ctl_access(1'b0, 2'd0, 20'h0);
    exp_q.push_back(mk(2'd1, 1'b0, 20'h0, 1'b0, WP ? 8'd4 : 8'd3));
    ctl_access(1'b1, 2'd0, 20'h0BCDA);
    exp_q.push_back(mk(2'd2, 1'b1, WP ? 20'h1BCDA : 20'h0BCDA, 1'b0, 8'd3));
    chk_read(2'd0);
    check("ctl_rdata_hold", {12'd0, ctl_rdata}, {12'd0, (WP ? 20'h1BCDA : 20'h0BCD5)});

    // reset during ISSUE of a loader write
    @(negedge CLK);
    ld_addr = 2'd3; ld_wdata = 20'hAAAAA; ld_req = 1'b1;
    @(posedge CLK); #1;
    check("mid_state_issue", {29'd0, dbgState}, {29'd0, ISSUE});
    RST = 1'b1;
    @(negedge CLK);
    check("mid_wren_gated", {31'd0, ram_wren}, 32'd0);
    @(negedge CLK);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_wren", {31'd0, ram_wren}, 32'd0);
    check("mid_ld_ack", {31'd0, ld_ack}, 32'd0);
    RST = 1'b0; ld_req = 1'b0;
    repeat (4) @(negedge CLK);
    exp_q.push_back(mk(2'd1, 1'b1, 20'h12345, 1'b0, 8'd3));
    ctl_access(1'b0, 2'd3, 20'h0);

    repeat (5) @(negedge CLK);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sudoku_ram_arbiter.md
# sudoku_ram_arbiter

- Shares the single `sudokuRAM` port among three requesters: the puzzle loader (write-only), the interface controller (read/write) and the game checker (read-only).
- Sequences every access through a fixed IDLE→ISSUE→CAPTURE→ACK pipeline and returns read data per requester.
- When configured, enforces cell write-protection with a read-modify-write.
- Sits between the requesters and the 4-row × 20-bit board RAM in the top level.

## Interface
Parameters:
- none; widths come from the shared package (ROW_W=20, ADDR_W=2).

Ports (name, direction, width, meaning):
- CLK  in  1  system clock; one clock domain.
- RST  in  1  reset; synchronous, active-high.
- ld_req  in  1  loader request.
- ld_addr  in  2  loader row address.
- ld_wdata  in  20  loader row data.
- ld_ack  out  1  loader completion pulse.
- ctl_req  in  1  controller request.
- ctl_we  in  1  controller access type: 1 = write, 0 = read.
- ctl_addr  in  2  controller row address.
- ctl_wdata  in  20  controller row data.
- ctl_ack  out  1  controller completion pulse.
- ctl_rdata  out  20  controller read data.
- ctl_wp_err  out  1  controller write touched a protected cell.
- chk_req  in  1  checker request.
- chk_addr  in  2  checker row address.
- chk_ack  out  1  checker completion pulse.
- chk_rdata  out  20  checker read data.
- ram_addr  out  2  RAM address.
- ram_data  out  20  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  20  RAM read data; valid the cycle after the address is presented.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
Row format:
- [15:0] holds four cells; cell i is [4i+3:4i].
- [19:16] is the protect mask; bit 16+i protects cell i.

FSM states: IDLE, ISSUE, CAPTURE, WRITE (only with the macro), ACK.
- IDLE: if any req is high, select a winner and register its id, addr, wdata and we; go to ISSUE. Otherwise stay.
- Winner selection:
  - Loader has fixed highest priority.
  - Controller and checker alternate round-robin using a last-winner pointer. After reset the pointer favours the controller.
  - The pointer updates only when the controller or checker wins.
- ISSUE: drive ram_addr. ram_wren=1 for a loader write, or for a controller write when write-protection is compiled out. Next state is CAPTURE.
- CAPTURE: on a read, load ram_q into the winner's rdata register.
  - Protected controller write: merge ram_q with wdata into the write buffer and compute the violation flag.
  - Then go to WRITE (protected controller write) or ACK (all others).
- WRITE: ram_addr = captured addr, ram_data = merged buffer, ram_wren=1. Next state is ACK.
- ACK: one-cycle ack pulse to the winner only; go to IDLE.

Handshake:
- A requester holds req, addr, wdata and we stable until it sees ack.
- It deasserts req in the cycle after ack, so IDLE never resamples a completed request.

Read data:
- ctl_rdata and chk_rdata update only on that port's own read.
- Each holds its value until the port's next completed read.

Outputs:
- ram_wren is 0 in every state except as stated above.
- ram_addr and ram_data are don't-care when ram_wren=0 and no read is issued.

Boundary conditions:
- All three requesters high: loader wins. With the pointer at reset, controller then checker follow, each re-arbitrated from IDLE.
- A request arriving while busy waits; there is no queue beyond the held req.
- Reset mid-transaction: the next state is IDLE, ram_wren=0, no ack is issued, and the in-flight write is dropped if it has not yet been issued.

## Timing
- Reset values: all acks 0, ram_wren 0, ram_addr 0, ram_data 0, ctl_rdata 0, chk_rdata 0, ctl_wp_err 0, busy 0, pointer = controller.
- Request sampled in IDLE at cycle 0:
  - ISSUE at cycle 1, CAPTURE at cycle 2, ack at cycle 3.
  - A protected controller write acks at cycle 4.
- Read data is valid in the ack cycle.
- Minimum spacing between grants is 4 cycles (5 for a protected write).

## Configuration
Macro: `SUDOKU_RAM_WP_EN`.

Defined:
- A controller write becomes read-modify-write.
- Merged row = stored mask bits [19:16], stored value for each protected cell, ctl_wdata for each unprotected cell.
- ctl_wp_err is registered in CAPTURE. It is 1 if any protected cell in ctl_wdata differs from the stored value.
- ctl_wp_err is visible with ctl_ack and held until the next ctl_ack.
- Unprotected cells are still written.

Undefined:
- The WRITE state and merge logic are absent.
- Controller writes go directly to RAM in ISSUE.
- ctl_wp_err is tied to 0.
- Loader writes are never filtered in either build.

## Structure
- `sudoku_pkg` holds:
  - ROW_W, CELL_W=4, ADDR_W, NUM_CELLS=4;
  - the FSM state enum;
  - the requester-id enum (LD, CTL, CHK).
- Sub-module `sudoku_wp_merge` is a combinational block, instantiated only under the macro.
  - Inputs: stored row and ctl_wdata.
  - Outputs: merged row and violation flag.

## Test plan
- Loader writes row 2 = 20'hF1234, then the controller reads row 2 → ld_ack at cycle 3; ctl_rdata = 20'hF1234 with ctl_ack at cycle 3 of its own transaction.
- ld_req, ctl_req and chk_req all asserted from reset → grant order LD, CTL, CHK. A second simultaneous CTL+CHK pair is then served CTL, CHK.
- With `SUDOKU_RAM_WP_EN`, row 0 = 20'h1000A and the controller writes 20'h0BCD5 → stored row becomes 20'h1BCDA, ctl_wp_err = 1, ctl_ack at cycle 4.
- Same build, the controller writes 20'h0BCDA to that row → ctl_wp_err = 0 and the row is 20'h1BCDA.
- Without the macro, the same write as the first WP case → the row becomes 20'h0BCD5, ctl_wp_err = 0, ack at cycle 3.
- RST asserted during ISSUE of a loader write → no ld_ack; busy = 0 and ram_wren = 0 the next cycle. A subsequent read shows the row unchanged if the reset preceded the wren edge.
